// File: rtl/poly_actor_scheduler.sv
// Actor firing scheduler: SETUP firing, opcode enable check, INSTR firing.
// Define SCHED_WATCHDOG_EN to add the WAIT-state watchdog and err_timeout.
module poly_actor_scheduler #(
    parameter int          word_size  = 16,
    parameter logic [15:0] WDOG_LIMIT = 16'd4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sched_en,
    input  logic [word_size-1:0] pop_in_fifo_command,
    input  logic [word_size-1:0] pop_in_fifo_data,
    input  logic [word_size-1:0] free_out_fifo,
    input  logic [7:0]           instr,
    input  logic [4:0]           arg2,
    input  logic                 done_fsm2,
    output logic                 start_fsm2,
    output logic [1:0]           next_instr,
    output logic                 busy,
    output logic                 err_opcode,
    output logic                 err_timeout,
    output logic [word_size-1:0] fire_count
);

    localparam int XW = word_size + 1;

    typedef enum logic [2:0] {
        IDLE,
        FIRE_SETUP,
        WAIT_SETUP,
        CHECK_INSTR,
        FIRE_INSTR,
        WAIT_INSTR
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [7:0]     instr_q;
    logic [4:0]     arg2_q;
    logic           latch_en;
    logic           fire_inc;
    logic           ins_ok;
    logic           ins_bad;
    logic           wdog_hit;
    logic [XW-1:0]  data_x;
    logic [XW-1:0]  free_x;
    logic [XW-1:0]  n_x;
    logic [XW-1:0]  n1_x;

    // One extra bit so arg2+1 can never wrap in the compares.
    assign data_x = {1'b0, pop_in_fifo_data};
    assign free_x = {1'b0, free_out_fifo};
    assign n_x    = XW'(arg2_q);
    assign n1_x   = n_x + XW'(1);

    always_comb begin
        ins_ok  = 1'b0;
        ins_bad = 1'b0;
        unique case (1'b1)
            (instr_q == 8'd0): ins_ok = (data_x >= n1_x) && (free_x >= XW'(1));
            (instr_q == 8'd1): ins_ok = (data_x >= XW'(1)) && (free_x >= XW'(1));
            (instr_q == 8'd2): ins_ok = (data_x >= n_x) && (free_x >= n1_x);
            (instr_q == 8'd3): ins_ok = 1'b1;
            default:           ins_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        latch_en = 1'b0;
        fire_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (sched_en && (|pop_in_fifo_command))
                    state_nx = FIRE_SETUP;
            end
            FIRE_SETUP: state_nx = WAIT_SETUP;
            WAIT_SETUP: begin
                if (done_fsm2) begin
                    latch_en = 1'b1;
                    state_nx = CHECK_INSTR;
                end else if (wdog_hit) begin
                    state_nx = IDLE;
                end
            end
            CHECK_INSTR: begin
                if (ins_bad)
                    state_nx = IDLE;
                else if (ins_ok)
                    state_nx = FIRE_INSTR;
            end
            FIRE_INSTR: state_nx = WAIT_INSTR;
            WAIT_INSTR: begin
                if (done_fsm2) begin
                    fire_inc = 1'b1;
                    state_nx = IDLE;
                end else if (wdog_hit) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign start_fsm2 = (state == FIRE_SETUP) || (state == FIRE_INSTR);
    assign next_instr = ((state == FIRE_INSTR) || (state == WAIT_INSTR))
                        ? 2'b01 : 2'b00;
    assign busy       = (state != IDLE);
    assign err_opcode = (state == CHECK_INSTR) && ins_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            instr_q    <= '0;
            arg2_q     <= '0;
            fire_count <= '0;
        end else begin
            state <= state_nx;
            if (latch_en) begin
                instr_q <= instr;
                arg2_q  <= arg2;
            end
            if (fire_inc)
                fire_count <= fire_count + word_size'(1);
        end
    end

`ifdef SCHED_WATCHDOG_EN
    logic [15:0] wdog_cnt;
    logic        in_wait;

    // Counter sits at zero outside WAIT states, so it restarts on every entry.
    assign in_wait  = (state == WAIT_SETUP) || (state == WAIT_INSTR);
    assign wdog_hit = in_wait &&
                      (({1'b0, wdog_cnt} + 17'd1) >= {1'b0, WDOG_LIMIT});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (in_wait && !done_fsm2)
                wdog_cnt <= wdog_cnt + 16'd1;
            else
                wdog_cnt <= '0;
            if (wdog_hit && !done_fsm2)
                err_timeout <= 1'b1;
        end
    end
`else
    logic unused_wdog;

    assign unused_wdog = ^WDOG_LIMIT;
    assign wdog_hit    = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_poly_actor_scheduler.sv
// Bench for poly_actor_scheduler: directed cases plus random traffic
// checked every cycle against a firing-level reference model.
module tb_poly_actor_scheduler;

    localparam int WS = 16;
`ifdef SCHED_WATCHDOG_EN
    localparam logic [15:0] WDL     = 16'd16;
    localparam bit          WDOG_ON = 1'b1;
`else
    localparam logic [15:0] WDL     = 16'd4096;
    localparam bit          WDOG_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sched_en = 1'b0;
    logic [WS-1:0] cmd = '0;
    logic [WS-1:0] data = '0;
    logic [WS-1:0] free = '0;
    logic [7:0]    instr = '0;
    logic [4:0]    arg2 = '0;
    logic          done = 1'b0;

    logic          start, busy, eop, eto;
    logic [1:0]    ni;
    logic [WS-1:0] fc;
    logic          start8, busy8, eop8, eto8;
    logic [1:0]    ni8;
    logic [7:0]    fc8;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    poly_actor_scheduler #(.word_size(WS), .WDOG_LIMIT(WDL)) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en),
        .pop_in_fifo_command(cmd), .pop_in_fifo_data(data),
        .free_out_fifo(free), .instr(instr), .arg2(arg2),
        .done_fsm2(done), .start_fsm2(start), .next_instr(ni),
        .busy(busy), .err_opcode(eop), .err_timeout(eto),
        .fire_count(fc)
    );

    // Narrow twin: same traffic (populations kept below 256), 8-bit counter wrap.
    poly_actor_scheduler #(.word_size(8), .WDOG_LIMIT(WDL)) dut8 (
        .clk(clk), .rst(rst), .sched_en(sched_en),
        .pop_in_fifo_command(cmd[7:0]), .pop_in_fifo_data(data[7:0]),
        .free_out_fifo(free[7:0]), .instr(instr), .arg2(arg2),
        .done_fsm2(done), .start_fsm2(start8), .next_instr(ni8),
        .busy(busy8), .err_opcode(eop8), .err_timeout(eto8),
        .fire_count(fc8)
    );

    always #5 clk = ~clk;

    // Reference model: phase of the current firing, latched command, counts.
    // 0 idle, 1 setup pulse, 2 awaiting setup done, 3 enable check,
    // 4 instr pulse, 5 awaiting instr done.
    int          m_ph = 0;
    int          m_op = 0;
    int          m_n  = 0;
    int          m_wd = 0;
    bit          m_to = 1'b0;
    int unsigned m_fc = 0;

    function automatic bit enabled(int op, int n, int d, int f);
        case (op)
            0:       return (d >= n + 1) && (f >= 1);
            1:       return (d >= 1) && (f >= 1);
            2:       return (d >= n) && (f >= n + 1);
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= 0; m_op <= 0; m_n <= 0;
            m_wd <= 0; m_to <= 1'b0; m_fc <= 0;
        end else begin
            case (m_ph)
                0: if (sched_en && int'(cmd) >= 1) m_ph <= 1;
                1: begin m_ph <= 2; m_wd <= 0; end
                3: begin
                    if (m_op > 3)
                        m_ph <= 0;
                    else if (enabled(m_op, m_n, int'(data), int'(free)))
                        m_ph <= 4;
                end
                4: begin m_ph <= 5; m_wd <= 0; end
                default: begin
                    if (done) begin
                        if (m_ph == 2) begin
                            m_op <= int'(instr);
                            m_n  <= int'(arg2);
                            m_ph <= 3;
                        end else begin
                            m_fc <= m_fc + 1;
                            m_ph <= 0;
                        end
                    end else if (WDOG_ON && m_wd + 1 >= int'(WDL)) begin
                        m_to <= 1'b1;
                        m_ph <= 0;
                    end else begin
                        m_wd <= m_wd + 1;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("start", 32'(start), 32'(m_ph == 1 || m_ph == 4));
            chk("next_instr", 32'(ni), 32'(m_ph == 4 || m_ph == 5));
            chk("busy", 32'(busy), 32'(m_ph != 0));
            chk("err_opcode", 32'(eop), 32'(m_ph == 3 && m_op > 3));
            chk("err_timeout", 32'(eto), 32'(m_to));
            chk("fire_count", 32'(fc), m_fc % 65536);
            chk("start8", 32'(start8), 32'(m_ph == 1 || m_ph == 4));
            chk("busy8", 32'(busy8), 32'(m_ph != 0));
            chk("fire_count8", 32'(fc8), m_fc % 256);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        cmp_on = 1'b1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_fc", 32'(fc), 0);
        chk("rst_eto", 32'(eto), 0);
        rst = 1'b1;
        tick();

        // STP N=3, data 4, free 8, done two cycles into each wait
        sched_en = 1; cmd = 1; data = 4; free = 8; instr = 0; arg2 = 3;
        tick();
        chk("stp_setup_start", 32'(start), 1);
        chk("stp_setup_ni", 32'(ni), 0);
        cmd = 0;
        tick();
        chk("stp_wait_start", 32'(start), 0);
        tick();
        done = 1;
        tick();
        done = 0;
        chk("stp_check_busy", 32'(busy), 1);
        chk("stp_check_start", 32'(start), 0);
        tick();
        chk("stp_instr_start", 32'(start), 1);
        chk("stp_instr_ni", 32'(ni), 1);
        tick();
        tick();
        done = 1;
        tick();
        done = 0;
        chk("stp_idle_busy", 32'(busy), 0);
        chk("stp_fc", 32'(fc), 1);

        // EVB b=5 blocked by free=5 until free rises to 6
        cmd = 1; instr = 2; arg2 = 5; data = 5; free = 5;
        tick();
        cmd = 0;
        tick();
        done = 1;
        tick();
        done = 0;
        repeat (3) begin
            tick();
            chk("evb_stall_start", 32'(start), 0);
            chk("evb_stall_busy", 32'(busy), 1);
        end
        free = 6;
        tick();
        chk("evb_fire_start", 32'(start), 1);
        chk("evb_fire_ni", 32'(ni), 1);
        tick();
        done = 1;
        tick();
        done = 0;
        chk("evb_fc", 32'(fc), 2);

        // Illegal opcode
        cmd = 1; instr = 8'd7;
        tick();
        cmd = 0;
        tick();
        done = 1;
        tick();
        done = 0;
        chk("bad_op_pulse", 32'(eop), 1);
        chk("bad_op_start", 32'(start), 0);
        tick();
        chk("bad_op_clear", 32'(eop), 0);
        chk("bad_op_idle", 32'(busy), 0);
        chk("bad_op_fc", 32'(fc), 2);

        // Reset during WAIT_INSTR
        cmd = 1; instr = 3;
        tick();
        cmd = 0;
        tick();
        done = 1;
        tick();
        done = 0;
        tick();
        tick();
        chk("mid_busy", 32'(busy), 1);
        chk("mid_ni", 32'(ni), 1);
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ni", 32'(ni), 0);
        chk("arst_start", 32'(start), 0);
        chk("arst_fc", 32'(fc), 0);
        tick();
        rst = 1'b1;
        repeat (4) begin
            tick();
            chk("post_rst_idle", 32'(busy), 0);
        end

`ifdef SCHED_WATCHDOG_EN
        // done never returns: timeout on the 16th WAIT cycle
        cmd = 1; instr = 3;
        tick();
        cmd = 0;
        tick();
        repeat (15) tick();
        chk("wd_pre_busy", 32'(busy), 1);
        chk("wd_pre_eto", 32'(eto), 0);
        tick();
        chk("wd_eto", 32'(eto), 1);
        chk("wd_idle", 32'(busy), 0);
        cmd = 1; done = 1;
        repeat (8) tick();
        cmd = 0; done = 0;
        repeat (4) tick();
        chk("wd_sticky", 32'(eto), 1);
        pulse_rst();
        chk("wd_cleared", 32'(eto), 0);
`else
        // Without the watchdog the wait is unbounded
        cmd = 1; instr = 3;
        tick();
        cmd = 0;
        repeat (40) tick();
        chk("nowd_busy", 32'(busy), 1);
        chk("nowd_eto", 32'(eto), 0);
        done = 1;
        repeat (4) tick();
        done = 0;
        tick();
        chk("nowd_fc", 32'(fc), 1);
        pulse_rst();
`endif

        // 256 back-to-back firings: 8-bit counter wraps, 16-bit reads 256
        sched_en = 1; cmd = 1; instr = 3; done = 1;
        for (int i = 0; i < 4000 && m_fc < 256; i++) tick();
        cmd = 0; done = 0;
        repeat (2) tick();
        chk("wrap_fc16", 32'(fc), 256);
        chk("wrap_fc8", 32'(fc8), 0);
        chk("wrap_idle", 32'(busy), 0);

        for (int i = 0; i < 4000; i++) begin
            tick();
            rst      = ($urandom % 400) != 0;
            sched_en = ($urandom % 4) != 0;
            cmd      = WS'($urandom % 3);
            data     = WS'($urandom_range(0, 40));
            free     = WS'($urandom_range(0, 40));
            instr    = ($urandom % 8 == 0) ? 8'($urandom_range(4, 255))
                                           : 8'($urandom % 4);
            arg2     = 5'($urandom);
            done     = ($urandom % 3) == 0;
        end
        rst = 1; cmd = 0; done = 0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/poly_actor_scheduler.md
POLY_ACTOR_SCHEDULER -- requirements
Module: poly_actor_scheduler

Interface
REQ-001 Parameter word_size, default 16, width of the FIFO population and fire-count buses.
REQ-002 Parameter WDOG_LIMIT, default 16'd4096, watchdog cycle limit (used only under REQ-032).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 sched_en  in  1  1 = scheduler may begin new firings.
REQ-006 pop_in_fifo_command  in  word_size  command input FIFO population.
REQ-007 pop_in_fifo_data  in  word_size  data input FIFO population.
REQ-008 free_out_fifo  in  word_size  free slots in output result/status FIFO.
REQ-009 instr  in  8  opcode decoded by the actor (0=STP, 1=EVP, 2=EVB, 3=RST).
REQ-010 arg2  in  5  N (STP) or b (EVB) from the decoded command.
REQ-011 done_fsm2  in  1  actor firing-complete pulse.
REQ-012 start_fsm2  out  1  one-cycle actor invoke pulse.
REQ-013 next_instr  out  2  firing mode: 2'b00 SETUP, 2'b01 INSTR.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 err_opcode  out  1  one-cycle pulse on an illegal opcode.
REQ-016 err_timeout  out  1  sticky watchdog flag.
REQ-017 fire_count  out  word_size  count of completed INSTR firings.

Function
REQ-018 States SHALL be IDLE, FIRE_SETUP, WAIT_SETUP, CHECK_INSTR, FIRE_INSTR and WAIT_INSTR.
REQ-019 IDLE SHALL go to FIRE_SETUP when sched_en=1 and pop_in_fifo_command>=1; otherwise it SHALL stay in IDLE.
REQ-020 FIRE_SETUP SHALL drive start_fsm2=1 and next_instr=00 for exactly one cycle, then go to WAIT_SETUP.
REQ-021 WAIT_SETUP SHALL hold next_instr=00; when done_fsm2=1 it SHALL latch instr and arg2 into internal registers in that cycle and go to CHECK_INSTR.
REQ-022 The CHECK_INSTR enable rule SHALL be, using the latched values:
- STP: data>=arg2+1 and free>=1.
- EVP: data>=1 and free>=1.
- EVB: data>=arg2 and free>=arg2+1.
- RST: always enabled.
REQ-023 Compares SHALL be unsigned and at word_size+1 bits so that arg2+1 never wraps.
REQ-024 CHECK_INSTR SHALL go to FIRE_INSTR when enabled, otherwise stay in CHECK_INSTR; sched_en SHALL NOT block this transition.
REQ-025 An opcode greater than 3 in CHECK_INSTR SHALL pulse err_opcode for one cycle and return to IDLE with no INSTR firing.
REQ-026 FIRE_INSTR SHALL drive start_fsm2=1 and next_instr=01 for one cycle, then go to WAIT_INSTR.
REQ-027 WAIT_INSTR SHALL hold next_instr=01; on done_fsm2=1 it SHALL increment fire_count, wrapping to 0 past its maximum, and return to IDLE.
REQ-028 done_fsm2 SHALL be ignored in IDLE, FIRE_* and CHECK_INSTR states, including when it coincides with start_fsm2.
REQ-029 Minimum latency from IDLE to start of the INSTR firing, with done_fsm2 returned after k cycles, SHALL be 3+k cycles.
REQ-030 Deasserting sched_en mid-firing SHALL NOT abort the firing; it SHALL take effect only at IDLE.

Reset
REQ-031 While rst=0:
- state=IDLE.
- start_fsm2=0, next_instr=00, busy=0.
- err_opcode=0, err_timeout=0, fire_count=0.
- latched instr/arg2 cleared to 0.
- watchdog counter cleared to 0.
Reset asserted mid-firing SHALL abandon the firing with no output pulse.

Configuration
REQ-032 With macro SCHED_WATCHDOG_EN defined:
- a 16-bit counter SHALL count cycles in WAIT_SETUP/WAIT_INSTR and clear on entry to either state.
- on reaching WDOG_LIMIT it SHALL set err_timeout (sticky until reset) and go to IDLE.
Without SCHED_WATCHDOG_EN, no counter SHALL exist, err_timeout SHALL be constant 0, and WAIT states SHALL wait indefinitely.

Verification
REQ-033 cmd pop=1, data pop=4, free=8, instr=0 (STP), arg2=3, done after 2 cycles -> two start_fsm2 pulses (next_instr 00 then 01), fire_count=1, back in IDLE.
REQ-034 EVB, arg2=5, data=5, free=5 -> stays in CHECK_INSTR with no start; raise free to 6 -> FIRE_INSTR on the next cycle.
REQ-035 instr=8'd7 after setup -> err_opcode pulses once, no INSTR start, state IDLE, fire_count unchanged.
REQ-036 rst pulled low in WAIT_INSTR -> immediately all outputs 0 and IDLE; after release with cmd pop=0 -> stays IDLE.
REQ-037 SCHED_WATCHDOG_EN, WDOG_LIMIT=16, done_fsm2 never arrives -> err_timeout=1 after 16 WAIT cycles, IDLE, flag held until reset.
REQ-038 fire_count preloaded by 65535 firings, one more firing -> fire_count=0.
